// File: rtl/pixel_packet_fifo.sv
// pixel_packet_fifo
// Circular buffer of {x, y, colour} pixel packets. It sits between the packet generator,
// which pushes without back-pressure, and the I2C slave, which reads the head entry and
// pops it. Pushes that arrive while the buffer is full are dropped, and each drop is counted.
//
// Optional build macro:
//   PIXEL_FIFO_COALESCE_EN - discard a push that repeats the last accepted packet.
//                            This suppresses duplicate pixels produced by overlapping
//                            brush or symmetry expansion.
module pixel_packet_fifo #(
    parameter int DEPTH_LOG2 = 3,
    parameter int XW         = 8,
    parameter int YW         = 8,
    parameter int CW         = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  wr_valid,
    input  logic [XW-1:0]         wr_x,
    input  logic [YW-1:0]         wr_y,
    input  logic [CW-1:0]         wr_color,
    input  logic                  rd_pop,
    output logic                  rd_valid,
    output logic [XW-1:0]         rd_x,
    output logic [YW-1:0]         rd_y,
    output logic [CW-1:0]         rd_color,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  overflow,
    output logic [7:0]            drop_cnt
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int EW    = XW + YW + CW;

    logic [EW-1:0]         mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [EW-1:0]         wr_data;
    logic                  is_dup;
    logic                  pop_ok;
    logic                  push_ok;
    logic                  drop;
    logic [DEPTH_LOG2:0]   count_next;

    assign wr_data = {wr_x, wr_y, wr_color};

`ifdef PIXEL_FIFO_COALESCE_EN
    logic [EW-1:0] last_entry;
    logic          last_valid;

    // Remember the most recently accepted packet. Later pops do not affect it.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            last_entry <= '0;
            last_valid <= 1'b0;
        end else if (push_ok) begin
            last_entry <= wr_data;
            last_valid <= 1'b1;
        end
    end

    assign is_dup = last_valid && (wr_data == last_entry);
`else
    assign is_dup = 1'b0;
`endif

    // A pop needs a stored entry. A push needs room, unless a pop frees a slot this cycle.
    assign pop_ok  = rd_pop && rd_valid;
    assign push_ok = wr_valid && !is_dup && (!full || pop_ok);
    assign drop    = wr_valid && !is_dup && full && !rd_pop;

    // Work out the next occupancy so that count, full and rd_valid can all be registered.
    always_comb begin
        count_next = count;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count + (DEPTH_LOG2+1)'(1);
            2'b01:   count_next = count - (DEPTH_LOG2+1)'(1);
            default: count_next = count;
        endcase
    end

    // Write the storage array. It has no reset because stale contents are never presented.
    always_ff @(posedge clk) begin
        if (push_ok && !rst && !clear) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Update the pointers, occupancy and drop bookkeeping. A flush wins over any push or pop.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            rd_valid <= 1'b0;
            overflow <= 1'b0;
            drop_cnt <= 8'd0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            count    <= count_next;
            full     <= (count_next == (DEPTH_LOG2+1)'(DEPTH));
            rd_valid <= (count_next != '0);
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end
        end
    end

    // The head entry is shown ahead of any pop. It reads as zero while the buffer is empty.
    assign {rd_x, rd_y, rd_color} = rd_valid ? mem[rd_ptr] : '0;

endmodule
